// File: rtl/rob_nway_pkg.sv
// Shared definitions for the N-wide reorder buffer: sizing constants,
// the per-entry packet layout and ring-pointer arithmetic.
package rob_nway_pkg;

    localparam int ROB_SIZE = 32;
    localparam int ROB_LEN  = $clog2(ROB_SIZE);
    localparam int PRF_LEN  = 6;
    localparam int XLEN     = 32;
    localparam int AREG_LEN = 5;

    typedef struct packed {
        logic                valid;
        logic                executed;
        logic                mis_pred;
        logic [XLEN-1:0]     PC;
        logic [AREG_LEN-1:0] dest_areg_idx;
        logic [PRF_LEN-1:0]  dest_preg_idx;
    } ROB_PACKET;

    // Ring pointer advance; ROB_SIZE is a power of two so truncation is the modulo
    function automatic logic [ROB_LEN-1:0] rob_ptr_add(input logic [ROB_LEN-1:0] p, input int k);
        return p + ROB_LEN'(k);
    endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Commit prefix selector: given the ready/mispredict bits of the head window,
// picks the contiguous run of retiring lanes, the retire count and the flush.
module rob_commit_sel #(
    parameter int COMMIT_W = 2,
    parameter int M_W      = $clog2(COMMIT_W + 1)
) (
    input  logic [COMMIT_W-1:0] win_ready,
    input  logic [COMMIT_W-1:0] win_mis,
    output logic [COMMIT_W-1:0] commit_valid,
    output logic [M_W-1:0]      commit_cnt,
    output logic                flush
);

    logic blocked;

    // Walk oldest-first; stop at the first unready lane or just after a mispredicted one
    always_comb begin
        commit_valid = '0;
        commit_cnt   = '0;
        flush        = 1'b0;
        blocked      = 1'b0;
        for (int j = 0; j < COMMIT_W; j++) begin
            if (!blocked && win_ready[j]) begin
                commit_valid[j] = 1'b1;
                commit_cnt      = commit_cnt + M_W'(1);
                if (win_mis[j]) begin
                    flush   = 1'b1;
                    blocked = 1'b1;
                end
            end else begin
                blocked = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_nway.sv
// N-wide reorder buffer: in-order multi-lane dispatch, CDB completion marking,
// in-order multi-lane retirement and flush on a retiring mispredicted branch.
// Optional build macro ROB_DEBUG_EN adds the rob_packets snapshot port and
// protocol checks on dispatch shape and completion targets.
module rob_nway
    import rob_nway_pkg::*;
#(
    parameter int DISPATCH_W = 2,
    parameter int COMMIT_W   = 2,
    parameter int CDB_W      = 2
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [DISPATCH_W-1:0]                dispatch_valid,
    input  logic [DISPATCH_W-1:0][XLEN-1:0]      dispatch_PC,
    input  logic [DISPATCH_W-1:0][AREG_LEN-1:0]  dispatch_dest_areg_idx,
    input  logic [DISPATCH_W-1:0][PRF_LEN-1:0]   dispatch_dest_preg_idx,
    output logic [DISPATCH_W-1:0][ROB_LEN-1:0]   dispatch_rob_idx,
    output logic [ROB_LEN:0]                     rob_free_cnt,
    output logic                                 dispatch_accept,
    input  logic [CDB_W-1:0]                     cdb_valid,
    input  logic [CDB_W-1:0][ROB_LEN-1:0]        cdb_rob_idx,
    input  logic [CDB_W-1:0]                     cdb_mis_pred,
    output logic [COMMIT_W-1:0]                  commit_valid,
    output logic [COMMIT_W-1:0][AREG_LEN-1:0]    commit_dest_areg_idx,
    output logic [COMMIT_W-1:0][PRF_LEN-1:0]     commit_dest_preg_idx,
    output logic [COMMIT_W-1:0][XLEN-1:0]        commit_PC,
    output logic                                 rob_flush,
    output logic [ROB_LEN-1:0]                   rob_head,
    output logic [ROB_LEN-1:0]                   rob_tail,
    output logic                                 rob_empty,
    output logic                                 rob_full
`ifdef ROB_DEBUG_EN
    ,
    output ROB_PACKET [ROB_SIZE-1:0]             rob_packets
`endif
);

    localparam int CNT_W = ROB_LEN + 1;
    localparam int M_W   = $clog2(COMMIT_W + 1);

    logic [ROB_SIZE-1:0] ent_valid;
    logic [ROB_SIZE-1:0] ent_exec;
    logic [ROB_SIZE-1:0] ent_mis;
    logic [XLEN-1:0]     ent_pc   [ROB_SIZE];
    logic [AREG_LEN-1:0] ent_areg [ROB_SIZE];
    logic [PRF_LEN-1:0]  ent_preg [ROB_SIZE];

    logic [ROB_LEN-1:0]  head;
    logic [ROB_LEN-1:0]  tail;
    logic [CNT_W-1:0]    count;

    logic [CNT_W-1:0]    disp_n;
    logic [COMMIT_W-1:0] win_ready;
    logic [COMMIT_W-1:0] win_mis;
    logic [M_W-1:0]      commit_cnt;
    logic [ROB_LEN-1:0]  head_next;

    // Group size; acceptance uses the registered count so freed slots are not reused this cycle
    always_comb begin
        disp_n = '0;
        for (int k = 0; k < DISPATCH_W; k++) begin
            disp_n = disp_n + CNT_W'(dispatch_valid[k]);
        end
    end

    assign rob_free_cnt    = CNT_W'(ROB_SIZE) - count;
    assign dispatch_accept = (disp_n <= rob_free_cnt) && !rob_flush;
    assign rob_empty       = (count == '0);
    assign rob_full        = (count == CNT_W'(ROB_SIZE));
    assign rob_head        = head;
    assign rob_tail        = tail;
    assign head_next       = head + ROB_LEN'(commit_cnt);

    // Lane slot indices from tail and the head window gathered for retirement
    always_comb begin
        for (int k = 0; k < DISPATCH_W; k++) begin
            dispatch_rob_idx[k] = rob_ptr_add(tail, k);
        end
        for (int j = 0; j < COMMIT_W; j++) begin
            win_ready[j]            = ent_valid[rob_ptr_add(head, j)] && ent_exec[rob_ptr_add(head, j)]
                                      && (CNT_W'(j) < count);
            win_mis[j]              = ent_mis[rob_ptr_add(head, j)];
            commit_dest_areg_idx[j] = ent_areg[rob_ptr_add(head, j)];
            commit_dest_preg_idx[j] = ent_preg[rob_ptr_add(head, j)];
            commit_PC[j]            = ent_pc[rob_ptr_add(head, j)];
        end
    end

    rob_commit_sel #(
        .COMMIT_W (COMMIT_W),
        .M_W      (M_W)
    ) u_commit_sel (
        .win_ready    (win_ready),
        .win_mis      (win_mis),
        .commit_valid (commit_valid),
        .commit_cnt   (commit_cnt),
        .flush        (rob_flush)
    );

    // Pointers, occupancy and per-entry status; flush squashes everything younger than the retired branch
    always_ff @(posedge clock) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_exec  <= '0;
            ent_mis   <= '0;
        end else if (rob_flush) begin
            head      <= head_next;
            tail      <= head_next;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            head  <= head_next;
            if (dispatch_accept) begin
                tail <= tail + ROB_LEN'(disp_n);
            end
            count <= count + (dispatch_accept ? disp_n : CNT_W'(0)) - CNT_W'(commit_cnt);
            for (int i = 0; i < CDB_W; i++) begin
                if (cdb_valid[i] && ent_valid[cdb_rob_idx[i]]) begin
                    ent_exec[cdb_rob_idx[i]] <= 1'b1;
                    if (cdb_mis_pred[i]) begin
                        ent_mis[cdb_rob_idx[i]] <= 1'b1;
                    end
                end
            end
            for (int j = 0; j < COMMIT_W; j++) begin
                if (commit_valid[j]) begin
                    ent_valid[rob_ptr_add(head, j)] <= 1'b0;
                end
            end
            for (int k = 0; k < DISPATCH_W; k++) begin
                if (dispatch_accept && dispatch_valid[k]) begin
                    ent_valid[rob_ptr_add(tail, k)] <= 1'b1;
                    ent_exec[rob_ptr_add(tail, k)]  <= 1'b0;
                    ent_mis[rob_ptr_add(tail, k)]   <= 1'b0;
                end
            end
        end
    end

    // Entry payload capture on accepted dispatch; payload is meaningless until valid is set
    always_ff @(posedge clock) begin
        for (int k = 0; k < DISPATCH_W; k++) begin
            if (dispatch_accept && dispatch_valid[k]) begin
                ent_pc[rob_ptr_add(tail, k)]   <= dispatch_PC[k];
                ent_areg[rob_ptr_add(tail, k)] <= dispatch_dest_areg_idx[k];
                ent_preg[rob_ptr_add(tail, k)] <= dispatch_dest_preg_idx[k];
            end
        end
    end

`ifdef ROB_DEBUG_EN
    // Expose every entry for inspection
    always_comb begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            rob_packets[i] = '{valid: ent_valid[i], executed: ent_exec[i], mis_pred: ent_mis[i],
                               PC: ent_pc[i], dest_areg_idx: ent_areg[i], dest_preg_idx: ent_preg[i]};
        end
    end

    // Flag a gapped dispatch group and completions aimed at empty slots
    always_ff @(posedge clock) begin
        if (reset) begin
            assert ((dispatch_valid & (dispatch_valid + DISPATCH_W'(1))) == '0)
                else $error("rob_nway: non-contiguous dispatch_valid %b", dispatch_valid);
            for (int i = 0; i < CDB_W; i++) begin
                assert (!(cdb_valid[i] && !ent_valid[cdb_rob_idx[i]]))
                    else $error("rob_nway: CDB port %0d targets invalid entry %0d", i, cdb_rob_idx[i]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rob_nway.sv
// Bench for rob_nway: table-driven dispatch/complete/retire sequence plus
// hand-written corner sequences; retired payloads are checked against a
// scoreboard queue filled in dispatch order.
module tb_rob_nway;
    import rob_nway_pkg::*;

    localparam int DW = 2;
    localparam int CW = 2;
    localparam int BW = 2;

    logic                          clock = 1'b0;
    logic                          reset = 1'b0;
    logic [DW-1:0]                 dispatch_valid = '0;
    logic [DW-1:0][XLEN-1:0]       dispatch_PC = '0;
    logic [DW-1:0][AREG_LEN-1:0]   dispatch_dest_areg_idx = '0;
    logic [DW-1:0][PRF_LEN-1:0]    dispatch_dest_preg_idx = '0;
    logic [DW-1:0][ROB_LEN-1:0]    dispatch_rob_idx;
    logic [ROB_LEN:0]              rob_free_cnt;
    logic                          dispatch_accept;
    logic [BW-1:0]                 cdb_valid = '0;
    logic [BW-1:0][ROB_LEN-1:0]    cdb_rob_idx = '0;
    logic [BW-1:0]                 cdb_mis_pred = '0;
    logic [CW-1:0]                 commit_valid;
    logic [CW-1:0][AREG_LEN-1:0]   commit_dest_areg_idx;
    logic [CW-1:0][PRF_LEN-1:0]    commit_dest_preg_idx;
    logic [CW-1:0][XLEN-1:0]       commit_PC;
    logic                          rob_flush;
    logic [ROB_LEN-1:0]            rob_head;
    logic [ROB_LEN-1:0]            rob_tail;
    logic                          rob_empty;
    logic                          rob_full;
`ifdef ROB_DEBUG_EN
    ROB_PACKET [ROB_SIZE-1:0]      rob_packets;
`endif

    rob_nway #(.DISPATCH_W(DW), .COMMIT_W(CW), .CDB_W(BW)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .dispatch_valid         (dispatch_valid),
        .dispatch_PC            (dispatch_PC),
        .dispatch_dest_areg_idx (dispatch_dest_areg_idx),
        .dispatch_dest_preg_idx (dispatch_dest_preg_idx),
        .dispatch_rob_idx       (dispatch_rob_idx),
        .rob_free_cnt           (rob_free_cnt),
        .dispatch_accept        (dispatch_accept),
        .cdb_valid              (cdb_valid),
        .cdb_rob_idx            (cdb_rob_idx),
        .cdb_mis_pred           (cdb_mis_pred),
        .commit_valid           (commit_valid),
        .commit_dest_areg_idx   (commit_dest_areg_idx),
        .commit_dest_preg_idx   (commit_dest_preg_idx),
        .commit_PC              (commit_PC),
        .rob_flush              (rob_flush),
        .rob_head               (rob_head),
        .rob_tail               (rob_tail),
        .rob_empty              (rob_empty),
        .rob_full               (rob_full)
`ifdef ROB_DEBUG_EN
        ,
        .rob_packets            (rob_packets)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [AREG_LEN-1:0] areg;
        logic [PRF_LEN-1:0]  preg;
    } exp_t;

    typedef struct {
        logic [1:0]         dv;
        logic [1:0]         cv;
        logic [ROB_LEN-1:0] c0;
        logic [ROB_LEN-1:0] c1;
        logic [1:0]         cm;
        logic               acc;
        logic [1:0]         cvld;
        logic [ROB_LEN:0]   free;
        logic [ROB_LEN-1:0] tail;
        logic               empty;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[9];
    int   checks = 0;
    int   errors = 0;
    int   seq    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t payload(input int s);
        exp_t e;
        e.pc   = 32'h1000 + XLEN'(s * 4);
        e.areg = AREG_LEN'(s);
        e.preg = PRF_LEN'(s * 7 + 3);
        return e;
    endfunction

    task automatic present(input logic [1:0] dv);
        for (int k = 0; k < DW; k++) begin
            exp_t e;
            e = payload(seq + k);
            dispatch_valid[k]         = dv[k];
            dispatch_PC[k]            = e.pc;
            dispatch_dest_areg_idx[k] = e.areg;
            dispatch_dest_preg_idx[k] = e.preg;
        end
    endtask

    task automatic push_group(input logic [1:0] dv);
        for (int k = 0; k < DW; k++) begin
            if (dv[k]) begin
                sb_q.push_back(payload(seq));
                seq++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        dispatch_valid = '0;
        cdb_valid      = '0;
        cdb_mis_pred   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        sb_q.delete();
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (!rob_empty && n < 50) begin
            tick();
            n++;
        end
        chk(name, rob_empty, 1);
    endtask

    // Retirement monitor: every retiring lane must match the oldest outstanding dispatch
    always @(negedge clock) begin
        if (reset === 1'b1 && commit_valid != '0) begin
            chk("commit_prefix", ((commit_valid & (commit_valid + 2'b01)) == 2'b00), 1);
            for (int j = 0; j < CW; j++) begin
                if (commit_valid[j]) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL commit_unexpected: lane %0d preg %0h with no outstanding dispatch",
                                 j, commit_dest_preg_idx[j]);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("commit_preg", commit_dest_preg_idx[j], e.preg);
                        chk("commit_areg", commit_dest_areg_idx[j], e.areg);
                        chk("commit_pc", commit_PC[j], e.pc);
                    end
                end
            end
            if (rob_flush) sb_q.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        //            dv     cv     c0  c1  cm     acc  cvld   free tail empty
        tbl[0] = '{2'b11, 2'b00, 0,  0, 2'b00, 1'b1, 2'b00, 32,  0, 1'b1};
        tbl[1] = '{2'b11, 2'b00, 0,  0, 2'b00, 1'b1, 2'b00, 30,  2, 1'b0};
        tbl[2] = '{2'b00, 2'b01, 3,  0, 2'b00, 1'b1, 2'b00, 28,  4, 1'b0};
        tbl[3] = '{2'b00, 2'b01, 2,  0, 2'b00, 1'b1, 2'b00, 28,  4, 1'b0};
        tbl[4] = '{2'b00, 2'b11, 1,  1, 2'b00, 1'b1, 2'b00, 28,  4, 1'b0};
        tbl[5] = '{2'b00, 2'b10, 0,  0, 2'b00, 1'b1, 2'b00, 28,  4, 1'b0};
        tbl[6] = '{2'b00, 2'b00, 0,  0, 2'b00, 1'b1, 2'b11, 28,  4, 1'b0};
        tbl[7] = '{2'b00, 2'b00, 0,  0, 2'b00, 1'b1, 2'b11, 30,  4, 1'b0};
        tbl[8] = '{2'b00, 2'b00, 0,  0, 2'b00, 1'b1, 2'b00, 32,  4, 1'b1};

        do_reset();

        // Reset state
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_flush", rob_flush, 0);
        chk("rst_empty", rob_empty, 1);
        chk("rst_full", rob_full, 0);
        chk("rst_free", rob_free_cnt, 32);
        chk("rst_head", rob_head, 0);
        chk("rst_tail", rob_tail, 0);

        // In-order retire with out-of-order completion
        for (int r = 0; r < 9; r++) begin
            present(tbl[r].dv);
            cdb_valid      = tbl[r].cv;
            cdb_rob_idx[0] = tbl[r].c0;
            cdb_rob_idx[1] = tbl[r].c1;
            cdb_mis_pred   = tbl[r].cm;
            #1;
            chk($sformatf("tbl%0d_accept", r), dispatch_accept, tbl[r].acc);
            chk($sformatf("tbl%0d_commit_valid", r), commit_valid, tbl[r].cvld);
            chk($sformatf("tbl%0d_free", r), rob_free_cnt, tbl[r].free);
            chk($sformatf("tbl%0d_tail", r), rob_tail, tbl[r].tail);
            chk($sformatf("tbl%0d_empty", r), rob_empty, tbl[r].empty);
            if (tbl[r].acc) push_group(tbl[r].dv);
            tick();
        end
        chk("tbl_sb_drained", sb_q.size(), 0);

        // Full-width dispatch until full; the 17th group is refused
        do_reset();
        for (int i = 0; i < 16; i++) begin
            present(2'b11);
            #1;
            chk($sformatf("fill%0d_accept", i), dispatch_accept, 1);
            chk($sformatf("fill%0d_idx0", i), dispatch_rob_idx[0], (2 * i) % 32);
            chk($sformatf("fill%0d_idx1", i), dispatch_rob_idx[1], (2 * i + 1) % 32);
            push_group(2'b11);
            tick();
        end
        chk("fill_tail_wrap", rob_tail, 0);
        chk("fill_full", rob_full, 1);
        chk("fill_free", rob_free_cnt, 0);
        chk("fill_empty", rob_empty, 0);
        present(2'b11);
        #1;
        chk("fill17_accept", dispatch_accept, 0);
        tick();
        chk("fill17_tail", rob_tail, 0);
        chk("fill17_full", rob_full, 1);

        // Partial fit: one slot left
        do_reset();
        for (int i = 0; i < 15; i++) begin
            present(2'b11);
            push_group(2'b11);
            tick();
        end
        present(2'b01);
        push_group(2'b01);
        tick();
        chk("pfit_free", rob_free_cnt, 1);
        chk("pfit_tail", rob_tail, 31);
        present(2'b11);
        #1;
        chk("pfit_two_accept", dispatch_accept, 0);
        tick();
        chk("pfit_two_tail", rob_tail, 31);
        chk("pfit_two_free", rob_free_cnt, 1);
        present(2'b01);
        #1;
        chk("pfit_one_accept", dispatch_accept, 1);
        push_group(2'b01);
        tick();
        chk("pfit_one_full", rob_full, 1);
        chk("pfit_one_tail", rob_tail, 0);

        // Mispredict: entry 1 mispredicted, entry 0 executed
        do_reset();
        for (int i = 0; i < 3; i++) begin
            present(2'b11);
            push_group(2'b11);
            tick();
        end
        cdb_valid      = 2'b11;
        cdb_rob_idx[0] = 1;
        cdb_mis_pred   = 2'b01;
        cdb_rob_idx[1] = 0;
        tick();
        present(2'b11);
        #1;
        chk("mis_commit_valid", commit_valid, 2'b11);
        chk("mis_flush", rob_flush, 1);
        chk("mis_accept", dispatch_accept, 0);
        tick();
        chk("mis_head", rob_head, 2);
        chk("mis_tail", rob_tail, 2);
        chk("mis_empty", rob_empty, 1);
        chk("mis_free", rob_free_cnt, 32);
        chk("mis_flush_done", rob_flush, 0);
        present(2'b01);
        #1;
        chk("mis_redispatch_idx", dispatch_rob_idx[0], 2);
        push_group(2'b01);
        tick();
        cdb_valid      = 2'b01;
        cdb_rob_idx[0] = 2;
        tick();
        wait_empty("mis_redispatch_empty");
        chk("mis_redispatch_head", rob_head, 3);

        // Wrap commit: advance head to 30, then retire 30, 31, 0, 1
        do_reset();
        for (int i = 0; i < 15; i++) begin
            present(2'b11);
            push_group(2'b11);
            tick();
        end
        for (int i = 0; i < 15; i++) begin
            cdb_valid      = 2'b11;
            cdb_rob_idx[0] = ROB_LEN'(2 * i);
            cdb_rob_idx[1] = ROB_LEN'(2 * i + 1);
            tick();
        end
        wait_empty("wrap_pre_empty");
        chk("wrap_pre_head", rob_head, 30);
        present(2'b11);
        #1;
        chk("wrap_idx0_a", dispatch_rob_idx[0], 30);
        chk("wrap_idx1_a", dispatch_rob_idx[1], 31);
        push_group(2'b11);
        tick();
        present(2'b11);
        #1;
        chk("wrap_idx0_b", dispatch_rob_idx[0], 0);
        chk("wrap_idx1_b", dispatch_rob_idx[1], 1);
        push_group(2'b11);
        tick();
        cdb_valid      = 2'b11;
        cdb_rob_idx[0] = 30;
        cdb_rob_idx[1] = 31;
        tick();
        cdb_valid      = 2'b11;
        cdb_rob_idx[0] = 0;
        cdb_rob_idx[1] = 1;
        tick();
        wait_empty("wrap_empty");
        chk("wrap_head", rob_head, 2);
        chk("wrap_sb_drained", sb_q.size(), 0);

        // Reset mid-operation with live entries and a concurrent CDB write
        do_reset();
        for (int i = 0; i < 5; i++) begin
            present(2'b11);
            push_group(2'b11);
            tick();
        end
        chk("midrst_free_before", rob_free_cnt, 22);
        reset          = 1'b0;
        cdb_valid      = 2'b01;
        cdb_rob_idx[0] = 0;
        present(2'b11);
        tick();
        reset = 1'b1;
        sb_q.delete();
        chk("midrst_head", rob_head, 0);
        chk("midrst_tail", rob_tail, 0);
        chk("midrst_empty", rob_empty, 1);
        chk("midrst_free", rob_free_cnt, 32);
        chk("midrst_commit_valid", commit_valid, 0);
        present(2'b01);
        push_group(2'b01);
        tick();
        tick();
        chk("midrst_no_stale_exec", commit_valid, 0);
        cdb_valid      = 2'b01;
        cdb_rob_idx[0] = 0;
        tick();
        wait_empty("midrst_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_nway.md
Name: rob_nway

Overview:
- N-wide reorder buffer: dispatches up to DISPATCH_W instructions per cycle in program order and marks entries executed from up to CDB_W completion ports.
- Retires up to COMMIT_W consecutive executed entries per cycle to the RRAT/freelist.
- On retirement of a mispredicted branch, raises a one-cycle flush that squashes all younger entries.
- Sits between dispatch/rename and the RRAT. Successor to the single-issue rob.

Parameters:
- ROB_SIZE, 32, entry count; power of two, ≥ 4.
- DISPATCH_W, 2, dispatch lanes per cycle.
- COMMIT_W, 2, retire lanes per cycle.
- CDB_W, 2, completion ports.
- XLEN, 32, PC width.
- PRF_LEN, 6, physical register index width.
- ROB_LEN, $clog2(ROB_SIZE), entry index width (derived).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- dispatch_valid  in  DISPATCH_W  per-lane valid; must be a contiguous prefix (lane 0 first).
- dispatch_PC  in  DISPATCH_W×XLEN  PC per lane.
- dispatch_dest_areg_idx  in  DISPATCH_W×5  architectural destination.
- dispatch_dest_preg_idx  in  DISPATCH_W×PRF_LEN  allocated physical destination.
- dispatch_rob_idx  out  DISPATCH_W×ROB_LEN  entry index assigned to each lane (tail+k).
- rob_free_cnt  out  ROB_LEN+1  free entries.
- dispatch_accept  out  1  the dispatch group is accepted this cycle.
- cdb_valid  in  CDB_W  completion valid.
- cdb_rob_idx  in  CDB_W×ROB_LEN  completing entry.
- cdb_mis_pred  in  CDB_W  completing branch mispredicted.
- commit_valid  out  COMMIT_W  retire lane valid; always a contiguous prefix.
- commit_dest_areg_idx  out  COMMIT_W×5  retiring architectural destination.
- commit_dest_preg_idx  out  COMMIT_W×PRF_LEN  retiring physical destination.
- commit_PC  out  COMMIT_W×XLEN  retiring PC.
- rob_flush  out  1  mispredicted entry retired this cycle.
- rob_head  out  ROB_LEN  oldest entry.
- rob_tail  out  ROB_LEN  next allocation slot.
- rob_empty  out  1  count == 0.
- rob_full  out  1  count == ROB_SIZE.

Behaviour:
- State: per-entry {valid, executed, mis_pred, PC, areg, preg}; head, tail, count (ROB_LEN+1 bits).
- Reset (reset==0 at a rising edge):
  - All entries are invalid.
  - head = tail = count = 0.
  - Outputs: commit_valid = 0, rob_flush = 0, rob_empty = 1, rob_full = 0, rob_free_cnt = ROB_SIZE.
  - Reset asserted mid-operation discards all state in that cycle; CDB and dispatch inputs are ignored.
- Dispatch:
  - n = popcount(dispatch_valid).
  - dispatch_accept = (n ≤ rob_free_cnt) && !rob_flush.
  - All-or-nothing: no partial groups are accepted.
  - On accept, lane k writes entry (tail+k) mod ROB_SIZE with executed = 0 and mis_pred = 0, then tail += n.
  - dispatch_rob_idx is combinational from the current tail.
  - Dispatch on a flush cycle is dropped.
- Completion:
  - cdb_valid[i] sets executed and ORs in mis_pred at cdb_rob_idx[i] at the clock edge.
  - Completion to an invalid entry is ignored.
  - Multiple ports hitting the same entry are legal; their mis_pred bits are ORed.
  - Completion is visible to commit one cycle later; there is no same-cycle bypass.
- Commit (combinational from registered state):
  - Lane j is valid iff entry head+j is valid and executed, all lanes < j are valid, and no lane < j is mis_pred.
  - The first valid mis_pred lane retires (its own outputs valid), asserts rob_flush, and blocks the lanes after it.
  - Commit lanes never pass tail (count bounds them).
- Update:
  - head += m, where m is the number of retired lanes.
  - count = count + accepted n − m, evaluated with dispatch and commit in the same cycle.
  - Dispatch into slots freed in the same cycle is not allowed; free_cnt is based on registered count.
- Flush:
  - At the edge with rob_flush = 1, all entries are invalidated.
  - head = tail = head_old + m, count = 0.
  - CDB writes in that cycle are discarded.
- Wrap-around:
  - All pointer arithmetic is mod ROB_SIZE.
  - Full and empty are distinguished by count, never by head == tail alone.

Optional Feature:
- Macro: ROB_DEBUG_EN.
- Defined: adds output rob_packets (ROB_SIZE × ROB_PACKET) exposing every entry for the bench print routines.
- Defined: adds an assertion block that flags a non-contiguous dispatch_valid and a CDB write to an invalid entry via $error.
- Undefined: neither the port nor the checks exist; functional behaviour is identical.

Decomposition:
- Shared package (sys_defs): ROB_PACKET struct {valid, executed, mis_pred, PC, dest_areg_idx, dest_preg_idx}, ROB_SIZE, ROB_LEN, PRF_LEN, XLEN.
- One sub-module, rob_commit_sel: combinational prefix selector producing commit_valid, the retire count m, and the flush lane from head-window executed/mis_pred bits.

Test Plan:
- Dispatch full width: reset, then dispatch_valid = 2'b11 for 16 cycles → tail wraps to 0, rob_full = 1, and the 17th group gets dispatch_accept = 0.
- Partial fit: count = 31, dispatch 2 lanes → dispatch_accept = 0 and tail unchanged; 1 lane → accepted, rob_full = 1.
- In-order retire: dispatch entries 0–3; CDB completes 3, 2, then 1, 0 → no commit until entry 0 is executed; then commit_valid = 2'b11 for entries 0–1, then 2'b11 for entries 2–3, ending with rob_empty = 1.
- Mispredict:
  - Setup: entries 0–5 valid; entry 1 completes with mis_pred = 1 and entry 0 executed.
  - Response: commit_valid = 2'b11 and rob_flush = 1; next cycle head = tail = 2, count = 0.
  - Dispatch presented in the flush cycle is dropped.
- Wrap commit: with head = 30, retire entries 30, 31, 0, 1 → head = 2 and commit_dest_preg_idx values match dispatch order.
- Reset mid-operation: 10 entries live, reset = 0 for one edge → head = tail = 0, commit_valid = 0, and the CDB write in that cycle has no effect.
